washer_ctrl: RTL and testbench

Wash-cycle controller for the washing-machine design. It runs the power, program and start/pause state machine and steps the machine through its fill, wash, drain, rinse and spin phases on a 1-tick time base. It produces the `power_light`, `total_time`, `current_time` and `current_water` values that the seven-segment display stage consumes directly. All outputs are registered, and every displayed value is 0..99.

---
 rtl/washer_ctrl_if.sv | 29 ++
 rtl/washer_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_washer_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/washer_ctrl_if.sv
// Button/time-base inputs and display-stage outputs of the wash-cycle controller.
interface washer_ctrl_if;
  logic       tick;
  logic       power_btn;
  logic       start_btn;
  logic       mode_btn;
  logic       power_light;
  logic       run_light;
  logic       wash_light;
  logic       rinse_light;
  logic       spin_light;
  logic       buzz;
  logic [1:0] mode;
  logic [6:0] total_time;
  logic [6:0] current_time;
  logic [6:0] current_water;

  modport master (
    output tick, power_btn, start_btn, mode_btn,
    input  power_light, run_light, wash_light, rinse_light, spin_light, buzz,
           mode, total_time, current_time, current_water
  );

  modport slave (
    input  tick, power_btn, start_btn, mode_btn,
    output power_light, run_light, wash_light, rinse_light, spin_light, buzz,
           mode, total_time, current_time, current_water
  );
endinterface

// File: rtl/washer_ctrl.sv
// Wash-cycle controller: power/program/pause FSM stepping fill, wash, drain,
// rinse and spin phases on the tick time base; every output is registered.
module washer_ctrl #(
  parameter int WASH_T    = 9,
  parameter int RINSE_T   = 6,
  parameter int SPIN_T    = 3,
  parameter int WATER_LVL = 3,
  parameter int BUZZ_T    = 2
) (
  input  logic         clk,
  input  logic         rst,
  washer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF, S_IDLE, S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_DONE
  } state_t;

  typedef enum logic [1:0] {G_WASH, G_RINSE, G_SPIN} stage_t;

  localparam logic [6:0] LVL       = 7'(WATER_LVL);
  localparam logic [6:0] WASH_CNT  = 7'(WASH_T);
  localparam logic [6:0] RINSE_CNT = 7'(RINSE_T);
  localparam logic [6:0] SPIN_CNT  = 7'(SPIN_T);
  localparam logic [7:0] BUZZ_CNT  = 8'(BUZZ_T);
  localparam logic [6:0] WASH_LEN  = 7'(WATER_LVL + WASH_T);
  localparam logic [6:0] RINSE_DRY = 7'(WATER_LVL + RINSE_T);
  localparam logic [6:0] TOTAL0    = 7'(4 * WATER_LVL + WASH_T + RINSE_T + SPIN_T);
  localparam logic [6:0] TOTAL1    = 7'(2 * WATER_LVL + WASH_T + SPIN_T);
  localparam logic [6:0] TOTAL2    = 7'(2 * WATER_LVL + RINSE_T + SPIN_T);

  function automatic logic [6:0] program_total(input logic [1:0] m);
    case (m)
      2'd0:    return TOTAL0;
      2'd1:    return TOTAL1;
      2'd2:    return TOTAL2;
      default: return SPIN_CNT;
    endcase
  endfunction

  function automatic logic [6:0] dec_sat(input logic [6:0] v);
    return (v == 7'd0) ? 7'd0 : v - 7'd1;
  endfunction

  function automatic logic running(input state_t s);
    return s inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN};
  endfunction

  state_t     state_q, state_n;
  stage_t     stage_q, stage_n;
  logic       paused_q, paused_n;
  logic [1:0] mode_q, mode_n;
  logic [6:0] water_q, water_n;
  logic [6:0] cnt_q, cnt_n;
  logic [6:0] total_q, total_n;
  logic [6:0] cur_q, cur_n;
  logic [7:0] buzz_cnt_q, buzz_cnt_n;
  logic [2:0] lights_n;

  always_comb begin
    // NOTE: every next value defaults to its current value, so no latch is inferred.
    state_n    = state_q;
    stage_n    = stage_q;
    paused_n   = paused_q;
    mode_n     = mode_q;
    water_n    = water_q;
    cnt_n      = cnt_q;
    total_n    = total_q;
    cur_n      = cur_q;
    buzz_cnt_n = buzz_cnt_q;

    if (bus.power_btn) begin
      if (state_q == S_OFF) begin
        state_n = S_IDLE;
        total_n = TOTAL0;
      end else begin
        state_n    = S_OFF;
        stage_n    = G_WASH;
        paused_n   = 1'b0;
        mode_n     = 2'd0;
        water_n    = '0;
        cnt_n      = '0;
        total_n    = '0;
        cur_n      = '0;
        buzz_cnt_n = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_btn) begin
            paused_n = 1'b0;
            unique case (mode_q)
              2'd0, 2'd1: begin state_n = S_FILL; stage_n = G_WASH;  cur_n = WASH_LEN;  end
              2'd2:       begin state_n = S_FILL; stage_n = G_RINSE; cur_n = RINSE_DRY; end
              default:    begin
                state_n = S_SPIN; stage_n = G_SPIN; cnt_n = SPIN_CNT; cur_n = SPIN_CNT;
              end
            endcase
          end else if (bus.mode_btn) begin
            mode_n  = mode_q + 2'd1;
            total_n = program_total(mode_n);
          end
        end
        S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
          // A start press wins over a coincident tick; that tick is dropped.
          if (bus.start_btn) begin
            paused_n = !paused_q;
          end else if (bus.tick && !paused_q) begin
            total_n = dec_sat(total_q);
            cur_n   = dec_sat(cur_q);
            unique case (state_q)
              S_FILL: begin
                water_n = water_q + 7'd1;
                if (water_n == LVL) begin
                  state_n = (stage_q == G_WASH) ? S_WASH : S_RINSE;
                  cnt_n   = (stage_q == G_WASH) ? WASH_CNT : RINSE_CNT;
                end
              end
              S_DRAIN: begin
                water_n = water_q - 7'd1;
                if (water_n == 7'd0) begin
                  state_n = (stage_q == G_RINSE) ? S_FILL : S_SPIN;
                  cnt_n   = SPIN_CNT;
                end
              end
              S_WASH, S_RINSE: begin
                cnt_n = cnt_q - 7'd1;
                if (cnt_n == 7'd0) begin
                  // Stage boundary: reload current_time; an empty drain is skipped.
                  if (state_q == S_WASH && mode_q == 2'd0) begin
                    stage_n = G_RINSE;
                    state_n = (water_q == 7'd0) ? S_FILL : S_DRAIN;
                    cur_n   = water_q + LVL + RINSE_CNT;
                  end else begin
                    stage_n = G_SPIN;
                    state_n = (water_q == 7'd0) ? S_SPIN : S_DRAIN;
                    cnt_n   = SPIN_CNT;
                    cur_n   = water_q + SPIN_CNT;
                  end
                end
              end
              S_SPIN: begin
                cnt_n = cnt_q - 7'd1;
                if (cnt_n == 7'd0) begin
                  state_n    = S_DONE;
                  total_n    = '0;
                  cur_n      = '0;
                  buzz_cnt_n = '0;
                end
              end
              default: ;
            endcase
          end
        end
        S_DONE: begin
          if (bus.start_btn) begin
            state_n = S_IDLE;
            total_n = program_total(mode_q);
          end else if (bus.tick) begin
            buzz_cnt_n = buzz_cnt_q + 8'd1;
            if (buzz_cnt_n == BUZZ_CNT) begin
              state_n = S_IDLE;
              total_n = program_total(mode_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Lights are decoded from next-state so they switch with the state itself.
  always_comb begin
    lights_n = 3'b000;
    if (state_n == S_IDLE)
      lights_n = {1'b1, (mode_n == 2'd0) || (mode_n == 2'd2), mode_n < 2'd2};
    else if (running(state_n))
      lights_n = 3'b001 << stage_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_OFF;
      stage_q         <= G_WASH;
      paused_q        <= 1'b0;
      mode_q          <= 2'd0;
      water_q         <= '0;
      cnt_q           <= '0;
      total_q         <= '0;
      cur_q           <= '0;
      buzz_cnt_q      <= '0;
      bus.power_light <= 1'b0;
      bus.run_light   <= 1'b0;
      bus.wash_light  <= 1'b0;
      bus.rinse_light <= 1'b0;
      bus.spin_light  <= 1'b0;
      bus.buzz        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q         <= state_n;
      stage_q         <= stage_n;
      paused_q        <= paused_n;
      mode_q          <= mode_n;
      water_q         <= water_n;
      cnt_q           <= cnt_n;
      total_q         <= total_n;
      cur_q           <= cur_n;
      buzz_cnt_q      <= buzz_cnt_n;
      bus.power_light <= (state_n != S_OFF);
      bus.run_light   <= running(state_n) && !paused_n;
      bus.wash_light  <= lights_n[0];
      bus.rinse_light <= lights_n[1];
      bus.spin_light  <= lights_n[2];
      bus.buzz        <= (state_n == S_DONE);
    end
  end

  assign bus.mode          = mode_q;
  assign bus.total_time    = total_q;
  assign bus.current_time  = cur_q;
  assign bus.current_water = water_q;

endmodule

// File: tb/tb_washer_ctrl.sv
// Self-checking bench for washer_ctrl: directed scenarios plus random button
// traffic, compared against a per-tick timeline model of each program.
module tb_washer_ctrl;
  localparam int WASH_T    = 9;
  localparam int RINSE_T   = 6;
  localparam int SPIN_T    = 3;
  localparam int WATER_LVL = 3;
  localparam int BUZZ_T    = 2;

  logic clk = 1'b0;
  logic rst;
  washer_ctrl_if bus();

  washer_ctrl #(
    .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T),
    .WATER_LVL(WATER_LVL), .BUZZ_T(BUZZ_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum int {M_OFF, M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t m_st = M_OFF;
  int      m_mode = 0;
  int      m_k = 0;
  int      m_bt = 0;
  bit      m_paused = 1'b0;

  // Timeline of the selected program, indexed by ticks elapsed since start.
  int tl_water[64];
  int tl_cur[64];
  int tl_stage[64];
  int tl_len;

  function automatic bit has_stage(input int m, input int s);
    if (s == 0) return (m == 0) || (m == 1);
    if (s == 1) return (m == 0) || (m == 2);
    return 1'b1;
  endfunction

  task automatic build_timeline(input int m);
    int w;
    int k;
    w = 0;
    k = 0;
    tl_water[0] = 0;
    for (int s = 0; s < 3; s++) begin
      int seq[$];
      int run_len;
      if (!has_stage(m, s)) continue;
      seq = {};
      if (s != 0) for (int i = w - 1; i >= 0; i--) seq.push_back(i);
      if (s != 2) for (int i = 1; i <= WATER_LVL; i++) seq.push_back(i);
      run_len = (s == 0) ? WASH_T : (s == 1) ? RINSE_T : SPIN_T;
      w = (s == 2) ? 0 : WATER_LVL;
      for (int i = 0; i < run_len; i++) seq.push_back(w);
      foreach (seq[j]) begin
        tl_cur[k + j]       = seq.size() - j;
        tl_stage[k + j]     = s;
        tl_water[k + j + 1] = seq[j];
      end
      k += seq.size();
    end
    tl_len    = k;
    tl_cur[k] = 0;
  endtask

  task automatic model_step(input bit pw, input bit st, input bit tk, input bit md);
    build_timeline(m_mode);
    if (pw) begin
      m_st   = (m_st == M_OFF) ? M_IDLE : M_OFF;
      m_mode = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (st) begin m_st = M_RUN; m_k = 0; m_paused = 1'b0; end
          else if (md) m_mode = (m_mode + 1) % 4;
        end
        M_RUN: begin
          if (st) m_paused = !m_paused;
          else if (tk && !m_paused) begin
            m_k++;
            if (m_k == tl_len) begin m_st = M_DONE; m_bt = 0; end
          end
        end
        M_DONE: begin
          if (st) m_st = M_IDLE;
          else if (tk) begin
            m_bt++;
            if (m_bt == BUZZ_T) m_st = M_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int e_pw, e_run, e_wl, e_rl, e_sl, e_mode, e_tot, e_cur, e_wat, e_buzz;
    e_pw = 0; e_run = 0; e_wl = 0; e_rl = 0; e_sl = 0;
    e_mode = 0; e_tot = 0; e_cur = 0; e_wat = 0; e_buzz = 0;
    build_timeline(m_mode);
    case (m_st)
      M_IDLE: begin
        e_pw = 1; e_mode = m_mode; e_tot = tl_len;
        e_wl = has_stage(m_mode, 0); e_rl = has_stage(m_mode, 1); e_sl = 1;
      end
      M_RUN: begin
        e_pw = 1; e_run = !m_paused; e_mode = m_mode;
        e_tot = tl_len - m_k; e_cur = tl_cur[m_k]; e_wat = tl_water[m_k];
        e_wl = (tl_stage[m_k] == 0); e_rl = (tl_stage[m_k] == 1); e_sl = (tl_stage[m_k] == 2);
      end
      M_DONE: begin
        e_pw = 1; e_mode = m_mode; e_buzz = 1;
      end
      default: ;
    endcase
    check({tag, "/power_light"}, bus.power_light, e_pw);
    check({tag, "/run_light"}, bus.run_light, e_run);
    check({tag, "/wash_light"}, bus.wash_light, e_wl);
    check({tag, "/rinse_light"}, bus.rinse_light, e_rl);
    check({tag, "/spin_light"}, bus.spin_light, e_sl);
    check({tag, "/mode"}, bus.mode, e_mode);
    check({tag, "/total_time"}, bus.total_time, e_tot);
    check({tag, "/current_time"}, bus.current_time, e_cur);
    check({tag, "/current_water"}, bus.current_water, e_wat);
    check({tag, "/buzz"}, bus.buzz, e_buzz);
  endtask

  task automatic clear_inputs();
    bus.power_btn = 1'b0;
    bus.start_btn = 1'b0;
    bus.tick      = 1'b0;
    bus.mode_btn  = 1'b0;
  endtask

  // Called at a falling edge: drive, let the DUT sample, check at the next falling edge.
  task automatic step(input bit pw, input bit st, input bit tk, input bit md, input string tag);
    bus.power_btn = pw;
    bus.start_btn = st;
    bus.tick      = tk;
    bus.mode_btn  = md;
    @(posedge clk);
    model_step(pw, st, tk, md);
    #1 clear_inputs();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic reset_cycle(input string tag);
    rst           = 1'b1;
    bus.power_btn = 1'($urandom_range(0, 1));
    bus.start_btn = 1'($urandom_range(0, 1));
    bus.tick      = 1'b1;
    bus.mode_btn  = 1'($urandom_range(0, 1));
    @(posedge clk);
    m_st = M_OFF; m_mode = 0; m_k = 0; m_paused = 1'b0;
    #1 clear_inputs();
    @(negedge clk);
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    int exp_tot[4]  = '{18, 15, 3, 30};
    int exp_mode[4] = '{1, 2, 3, 0};
    int gap;

    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset_cycle("reset0");
    reset_cycle("reset1");

    // Power-on
    step(1, 0, 0, 0, "power_on");
    check("power_on/total_const", bus.total_time, 30);
    check("power_on/lights_const", {bus.wash_light, bus.rinse_light, bus.spin_light}, 3'b111);

    // Mode cycling
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, "mode_btn");
      step(0, 0, 1, 0, "mode_hold");
      check("mode_cycle/total_const", bus.total_time, exp_tot[i]);
      check("mode_cycle/mode_const", bus.mode, exp_mode[i]);
    end

    // Full program 0 with random gaps (back-to-back ticks when gap is 0)
    step(0, 1, 0, 0, "p0_start");
    check("p0_start/cur_const", bus.current_time, 12);
    for (int t = 1; t <= 30; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(0, 0, 0, 1'($urandom_range(0, 1)), "p0_gap");
      step(0, 0, 1, 1'($urandom_range(0, 1)), "p0_tick");
      if (t == 3)  check("p0_t3/water_const", bus.current_water, 3);
      if (t == 12) check("p0_t12/cur_const", bus.current_time, 12);
      if (t == 15) check("p0_t15/water_const", bus.current_water, 0);
      if (t == 24) begin
        check("p0_t24/cur_const", bus.current_time, 6);
        check("p0_t24/spin_const", bus.spin_light, 1);
      end
      if (t == 30) check("p0_t30/buzz_const", bus.buzz, 1);
    end
    step(0, 0, 1, 0, "buzz_tick1");
    check("buzz_tick1/buzz_const", bus.buzz, 1);
    step(0, 0, 1, 0, "buzz_tick2");
    check("buzz_tick2/buzz_const", bus.buzz, 0);
    check("buzz_tick2/total_const", bus.total_time, 30);

    // Pause and resume on mode 3
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "to_mode3");
    step(0, 1, 0, 0, "m3_start");
    step(0, 0, 1, 0, "m3_tick");
    step(0, 1, 0, 0, "m3_pause");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, "m3_paused_tick");
      check("m3_paused/total_const", bus.total_time, 2);
    end
    step(0, 1, 0, 0, "m3_resume");
    step(0, 0, 1, 0, "m3_tick");
    step(0, 0, 1, 0, "m3_tick");
    check("m3_end/total_const", bus.total_time, 0);
    check("m3_end/buzz_const", bus.buzz, 1);
    step(0, 1, 0, 0, "done_start");

    // Simultaneous events mid-wash
    step(0, 0, 0, 1, "to_mode0");
    step(0, 1, 0, 0, "sim_start");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "sim_tick");
    step(0, 1, 1, 0, "sim_start_tick");
    check("sim_start_tick/total_const", bus.total_time, 26);
    step(0, 1, 0, 0, "sim_resume");
    step(0, 0, 1, 0, "sim_tick");
    step(1, 1, 1, 0, "sim_power_all");
    check("sim_power_all/power_const", bus.power_light, 0);

    // Reset during FILL at water 2
    step(1, 0, 0, 0, "abort_power");
    step(0, 1, 0, 0, "abort_start");
    step(0, 0, 1, 0, "abort_tick");
    step(0, 0, 1, 0, "abort_tick");
    check("abort_fill/water_const", bus.current_water, 2);
    reset_cycle("abort_rst");
    check("abort_rst/water_const", bus.current_water, 0);
    step(1, 0, 0, 0, "abort_repower");
    check("abort_repower/total_const", bus.total_time, 30);

    // Random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
